mig7_tester: RTL and testbench

Parametrised traffic generator and checker for the MIG7 application interface. It replaces the single-word write/read stub. After calibration and a start request it writes a generated pattern over a programmable range of beats, reads the range back and compares every beat. It reports an error count, the first failing address and a pass flag, and can optionally loop forever with a new seed each pass. It sits beside the MIG instance in the external node and drives its user port directly.

---
 rtl/mig7_tester_pkg.sv | 28 ++
 rtl/mig7_tester_if.sv | 38 +++
 rtl/mig7_tester.sv | 250 +++++++++++++++++++++++++
 tb/tb_mig7_tester.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig7_tester_pkg.sv
// Shared types, command encodings and the data-pattern helper for mig7_tester.
package mig7_tester_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    // Widest data bus the pattern helper can fill; DATA_WIDTH must not exceed it.
    localparam int PAT_MAX_WIDTH = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Beat pattern: 32-bit lane k of beat index holds seed + index + k.
    function automatic logic [PAT_MAX_WIDTH-1:0] pattern_word(input logic [31:0] seed,
                                                              input logic [31:0] index);
        logic [PAT_MAX_WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < PAT_MAX_WIDTH / 32; k++) begin
            w[k*32 +: 32] = seed + index + 32'(k);
        end
        return w;
    endfunction

endpackage

// File: rtl/mig7_tester_if.sv
// MIG7 application (user) port bundle between the tester and the MIG instance.
interface mig7_tester_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0]   app_addr;
    logic [2:0]              app_cmd;
    logic                    app_en;
    logic [DATA_WIDTH-1:0]   app_wdf_data;
    logic                    app_wdf_end;
    logic [DATA_WIDTH/8-1:0] app_wdf_mask;
    logic                    app_wdf_wren;
    logic [DATA_WIDTH-1:0]   app_rd_data;
    logic                    app_rd_data_end;
    logic                    app_rd_data_valid;
    logic                    app_rdy;
    logic                    app_wdf_rdy;
    logic                    app_sr_req;
    logic                    app_ref_req;
    logic                    app_zq_req;
    logic                    app_sr_active;
    logic                    app_ref_ack;
    logic                    app_zq_ack;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask,
               app_wdf_wren, app_sr_req, app_ref_req, app_zq_req,
        input  app_rd_data, app_rd_data_end, app_rd_data_valid, app_rdy, app_wdf_rdy,
               app_sr_active, app_ref_ack, app_zq_ack
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask,
               app_wdf_wren, app_sr_req, app_ref_req, app_zq_req,
        output app_rd_data, app_rd_data_end, app_rd_data_valid, app_rdy, app_wdf_rdy,
               app_sr_active, app_ref_ack, app_zq_ack
    );
endinterface

// File: rtl/mig7_tester.sv
// Traffic generator/checker: writes a seeded pattern over a beat range through
// the MIG7 user port, reads it back in order and tallies mismatching beats.
module mig7_tester
    import mig7_tester_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16,
    parameter int ADDR_STEP  = 8,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  loop_en,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic [31:0]           seed,
    input  logic                  init_calib_complete,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_cnt,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [31:0]           pass_cnt,
    mig7_tester_if.master         mig
);

    localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [ERR_WIDTH-1:0]  ERR_MAX = {ERR_WIDTH{1'b1}};

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [CNT_WIDTH-1:0]   num_r;
    logic [31:0]            seed_r;
    logic [CNT_WIDTH-1:0]   wc;
    logic [CNT_WIDTH-1:0]   dc;
    logic [CNT_WIDTH-1:0]   rc;
    logic [ADDR_WIDTH-1:0]  rd_addr;

    logic                   cmd_fire;
    logic                   wdf_fire;
    logic                   rd_fire;
    logic [CNT_WIDTH-1:0]   wc_inc;
    logic [CNT_WIDTH-1:0]   dc_inc;
    logic [CNT_WIDTH-1:0]   rc_inc;
    logic                   wr_cmd_done;
    logic                   wr_data_done;
    logic                   rd_last;
    logic                   rd_mismatch;
    logic [31:0]            first_seed;
    logic [PAT_MAX_WIDTH-1:0] pat_first_full;
    logic [PAT_MAX_WIDTH-1:0] pat_wr_full;
    logic [PAT_MAX_WIDTH-1:0] pat_rd_full;
    logic [DATA_WIDTH-1:0]  pat_first;
    logic [DATA_WIDTH-1:0]  pat_wr_next;
    logic [DATA_WIDTH-1:0]  pat_rd;
    logic [ERR_WIDTH-1:0]   err_cnt_nxt;
    logic [ADDR_WIDTH-1:0]  err_addr_nxt;
    logic                   unused_ok;

    assign mig.app_wdf_end  = 1'b1;
    assign mig.app_wdf_mask = '0;
    assign mig.app_sr_req   = 1'b0;
    assign mig.app_ref_req  = 1'b0;
    assign mig.app_zq_req   = 1'b0;

    // Handshakes, counter look-ahead and the patterns for the next beat of each stream.
    always_comb begin
        cmd_fire     = mig.app_en & mig.app_rdy;
        wdf_fire     = mig.app_wdf_wren & mig.app_wdf_rdy;
        rd_fire      = (state == ST_READ) & mig.app_rd_data_valid;
        wc_inc       = wc + CNT_WIDTH'(1);
        dc_inc       = dc + CNT_WIDTH'(1);
        rc_inc       = rc + CNT_WIDTH'(1);
        wr_cmd_done  = (wc == num_r) | (cmd_fire & (wc_inc == num_r));
        wr_data_done = (dc == num_r) | (wdf_fire & (dc_inc == num_r));
        rd_last      = rd_fire & (rc_inc == num_r);
        first_seed   = (state == ST_IDLE) ? seed : seed_r + 32'd1;
        pat_first_full = pattern_word(first_seed, 32'd0);
        pat_wr_full    = pattern_word(seed_r, 32'(dc_inc));
        pat_rd_full    = pattern_word(seed_r, 32'(rc));
        pat_first    = pat_first_full[DATA_WIDTH-1:0];
        pat_wr_next  = pat_wr_full[DATA_WIDTH-1:0];
        pat_rd       = pat_rd_full[DATA_WIDTH-1:0];
        rd_mismatch  = mig.app_rd_data != pat_rd;
    end

    // Error tally: cleared at the start of a fresh test or after a clean loop pass, bumped per bad beat.
    always_comb begin
        err_cnt_nxt  = err_cnt;
        err_addr_nxt = err_addr;
        case (state)
            ST_IDLE: begin
                if (start && init_calib_complete) begin
                    err_cnt_nxt  = '0;
                    err_addr_nxt = '0;
                end
            end
            ST_READ: begin
                if (rd_fire && rd_mismatch) begin
                    if (err_cnt != ERR_MAX) begin
                        err_cnt_nxt = err_cnt + ERR_WIDTH'(1);
                    end
                    if (err_cnt == '0) begin
                        err_addr_nxt = rd_addr;
                    end
                end
            end
            ST_DONE: begin
                if (loop_en && start && pass) begin
                    err_cnt_nxt  = '0;
                    err_addr_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    // Sideband bits the tester never needs are folded here so nothing dangles.
    assign unused_ok = &{1'b0, mig.app_rd_data_end, mig.app_sr_active, mig.app_ref_ack,
                         mig.app_zq_ack, pat_first_full, pat_wr_full, pat_rd_full};

    // Main sequencer: owns the state, beat counters and every registered MIG request output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            base_addr        <= '0;
            num_r            <= '0;
            seed_r           <= '0;
            wc               <= '0;
            dc               <= '0;
            rc               <= '0;
            rd_addr          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b1;
            err_cnt          <= '0;
            err_addr         <= '0;
            pass_cnt         <= '0;
            mig.app_en       <= 1'b0;
            mig.app_addr     <= '0;
            mig.app_cmd      <= CMD_WRITE;
            mig.app_wdf_wren <= 1'b0;
            mig.app_wdf_data <= '0;
        end else begin
            err_cnt  <= err_cnt_nxt;
            err_addr <= err_addr_nxt;
            pass     <= (err_cnt_nxt == '0);
            case (state)
                ST_IDLE: begin
                    if (start && init_calib_complete) begin
                        base_addr <= start_addr;
                        num_r     <= num_words;
                        seed_r    <= seed;
                        wc        <= '0;
                        dc        <= '0;
                        rc        <= '0;
                        rd_addr   <= start_addr;
                        if (num_words == '0) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            pass_cnt <= pass_cnt + 32'd1;
                        end else begin
                            state            <= ST_WRITE;
                            busy             <= 1'b1;
                            mig.app_en       <= 1'b1;
                            mig.app_cmd      <= CMD_WRITE;
                            mig.app_addr     <= start_addr;
                            mig.app_wdf_wren <= 1'b1;
                            mig.app_wdf_data <= pat_first;
                        end
                    end
                end
                ST_WRITE: begin
                    if (cmd_fire) begin
                        wc <= wc_inc;
                        if (wc_inc == num_r) begin
                            mig.app_en <= 1'b0;
                        end else begin
                            mig.app_addr <= mig.app_addr + STEP;
                        end
                    end
                    if (wdf_fire) begin
                        dc <= dc_inc;
                        if (dc_inc == num_r) begin
                            mig.app_wdf_wren <= 1'b0;
                        end else begin
                            mig.app_wdf_data <= pat_wr_next;
                        end
                    end
                    if (wr_cmd_done && wr_data_done) begin
                        state        <= ST_READ;
                        wc           <= '0;
                        mig.app_en   <= 1'b1;
                        mig.app_cmd  <= CMD_READ;
                        mig.app_addr <= base_addr;
                    end
                end
                ST_READ: begin
                    if (cmd_fire) begin
                        wc <= wc_inc;
                        if (wc_inc == num_r) begin
                            mig.app_en <= 1'b0;
                        end else begin
                            mig.app_addr <= mig.app_addr + STEP;
                        end
                    end
                    if (rd_fire) begin
                        rc      <= rc_inc;
                        rd_addr <= rd_addr + STEP;
                    end
                    if (rd_last) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        mig.app_en <= 1'b0;
                        pass_cnt   <= pass_cnt + 32'd1;
                    end
                end
                ST_DONE: begin
                    if (loop_en && start) begin
                        seed_r  <= seed_r + 32'd1;
                        wc      <= '0;
                        dc      <= '0;
                        rc      <= '0;
                        rd_addr <= base_addr;
                        if (num_r == '0) begin
                            pass_cnt <= pass_cnt + 32'd1;
                        end else begin
                            state            <= ST_WRITE;
                            busy             <= 1'b1;
                            done             <= 1'b0;
                            mig.app_en       <= 1'b1;
                            mig.app_cmd      <= CMD_WRITE;
                            mig.app_addr     <= base_addr;
                            mig.app_wdf_wren <= 1'b1;
                            mig.app_wdf_data <= pat_first;
                        end
                    end else if (!start) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mig7_tester.sv
// Bench for mig7_tester: a MIG memory model answers the user port while a
// scoreboard checks every presented command and data beat against expectations.
module tb_mig7_tester;

    logic        clk;
    logic        rst;
    logic        start;
    logic        loop_en;
    logic [27:0] start_addr;
    logic [15:0] num_words;
    logic [31:0] seed;
    logic        init_calib_complete;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_cnt;
    logic [27:0] err_addr;
    logic [31:0] pass_cnt;

    int checks   = 0;
    int failures = 0;

    mig7_tester_if #(.ADDR_WIDTH(28), .DATA_WIDTH(128)) mig_bus ();

    mig7_tester #(
        .ADDR_WIDTH(28), .DATA_WIDTH(128), .CNT_WIDTH(16), .ADDR_STEP(8), .ERR_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .start_addr(start_addr),
        .num_words(num_words), .seed(seed), .init_calib_complete(init_calib_complete),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .err_addr(err_addr),
        .pass_cnt(pass_cnt), .mig(mig_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard expectations, pushed when a run is issued.
    logic [27:0]  exp_wr_addr[$];
    logic [127:0] exp_wr_data[$];
    logic [27:0]  exp_rd_addr[$];

    // MIG model state.
    logic [127:0] mem [logic [27:0]];
    logic [27:0]  wr_addr_q[$];
    logic [127:0] wr_data_q[$];
    logic [27:0]  rd_pend_q[$];
    bit           rand_rdy    = 1'b0;
    int           corrupt_idx = -1;
    int           rd_beat_idx = 0;
    int           n_wr_cmd    = 0;
    int           n_wr_data   = 0;
    int           n_rd_cmd    = 0;

    function automatic logic [127:0] bench_pattern(input logic [31:0] s, input int idx);
        logic [127:0] w;
        for (int k = 0; k < 4; k++) w[k*32 +: 32] = s + 32'(idx) + 32'(k);
        return w;
    endfunction

    // MIG model: sample handshakes mid-cycle, update ready/return lines just after the edge.
    initial begin
        logic [27:0]  a;
        logic [127:0] d;
        mig_bus.app_rdy = 1'b1;
        mig_bus.app_wdf_rdy = 1'b1;
        mig_bus.app_rd_data_valid = 1'b0;
        mig_bus.app_rd_data = '0;
        mig_bus.app_rd_data_end = 1'b0;
        mig_bus.app_sr_active = 1'b0;
        mig_bus.app_ref_ack = 1'b0;
        mig_bus.app_zq_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wr_addr_q.delete();
                wr_data_q.delete();
                rd_pend_q.delete();
            end else begin
                if (mig_bus.app_en && mig_bus.app_rdy) begin
                    if (mig_bus.app_cmd == 3'b000) begin
                        wr_addr_q.push_back(mig_bus.app_addr);
                        n_wr_cmd++;
                    end else begin
                        rd_pend_q.push_back(mig_bus.app_addr);
                        n_rd_cmd++;
                    end
                end
                if (mig_bus.app_wdf_wren && mig_bus.app_wdf_rdy) begin
                    wr_data_q.push_back(mig_bus.app_wdf_data);
                    n_wr_data++;
                end
                while (wr_addr_q.size() > 0 && wr_data_q.size() > 0) begin
                    a = wr_addr_q.pop_front();
                    mem[a] = wr_data_q.pop_front();
                end
            end
            @(posedge clk);
            #1;
            if (!rst && rd_pend_q.size() > 0 && (!rand_rdy || $urandom_range(0, 1) == 1)) begin
                a = rd_pend_q.pop_front();
                d = mem.exists(a) ? mem[a] : '0;
                if (rd_beat_idx == corrupt_idx) d[0] = ~d[0];
                rd_beat_idx++;
                mig_bus.app_rd_data_valid = 1'b1;
                mig_bus.app_rd_data = d;
                mig_bus.app_rd_data_end = 1'b1;
            end else begin
                mig_bus.app_rd_data_valid = 1'b0;
                mig_bus.app_rd_data_end = 1'b0;
            end
            mig_bus.app_rdy     = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            mig_bus.app_wdf_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: whatever the DUT presents (stalled or accepted) must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mig_bus.app_en) begin
                    checks++;
                    if (mig_bus.app_cmd == 3'b000) begin
                        if (exp_wr_addr.size() == 0) begin
                            failures++;
                            $display("[TB] FAIL wr_cmd_extra got addr=%h, required no command", mig_bus.app_addr);
                        end else begin
                            if (mig_bus.app_addr !== exp_wr_addr[0]) begin
                                failures++;
                                $display("[TB] FAIL wr_addr got %h, required %h", mig_bus.app_addr, exp_wr_addr[0]);
                            end
                            if (mig_bus.app_rdy) void'(exp_wr_addr.pop_front());
                        end
                    end else if (mig_bus.app_cmd == 3'b001) begin
                        if (exp_rd_addr.size() == 0) begin
                            failures++;
                            $display("[TB] FAIL rd_cmd_extra got addr=%h, required no command", mig_bus.app_addr);
                        end else begin
                            if (mig_bus.app_addr !== exp_rd_addr[0]) begin
                                failures++;
                                $display("[TB] FAIL rd_addr got %h, required %h", mig_bus.app_addr, exp_rd_addr[0]);
                            end
                            if (mig_bus.app_rdy) void'(exp_rd_addr.pop_front());
                        end
                    end else begin
                        failures++;
                        $display("[TB] FAIL app_cmd got %b, required 000 or 001", mig_bus.app_cmd);
                    end
                end
                if (mig_bus.app_wdf_wren) begin
                    checks++;
                    if (exp_wr_data.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL wr_data_extra got %h, required no beat", mig_bus.app_wdf_data);
                    end else begin
                        if (mig_bus.app_wdf_data !== exp_wr_data[0]) begin
                            failures++;
                            $display("[TB] FAIL wr_data got %h, required %h", mig_bus.app_wdf_data, exp_wr_data[0]);
                        end
                        if (mig_bus.app_wdf_rdy) void'(exp_wr_data.pop_front());
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0;
        loop_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_wr_addr.delete();
        exp_wr_data.delete();
        exp_rd_addr.delete();
        rd_beat_idx = 0;
        n_wr_cmd = 0;
        n_wr_data = 0;
        n_rd_cmd = 0;
    endtask

    task automatic applyStimulus(input logic [27:0] a, input int n, input logic [31:0] s,
                                 input bit lp, input int passes);
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < n; i++) begin
                exp_wr_addr.push_back(a + 28'(i * 8));
                exp_rd_addr.push_back(a + 28'(i * 8));
                exp_wr_data.push_back(bench_pattern(s + 32'(p), i));
            end
        end
        @(posedge clk);
        #1;
        start_addr = a;
        num_words = 16'(n);
        seed = s;
        loop_en = lp;
        start = 1'b1;
    endtask

    task automatic waitDone(input string name);
        bit hit = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done) begin
                hit = 1'b1;
                break;
            end
        end
        checkOutput({name, "_done_timeout"}, 64'(hit), 64'd1);
    endtask

    task automatic checkTraffic(input string name, input int n);
        checkOutput({name, "_wr_cmds"}, 64'(n_wr_cmd), 64'(n));
        checkOutput({name, "_wr_beats"}, 64'(n_wr_data), 64'(n));
        checkOutput({name, "_rd_cmds"}, 64'(n_rd_cmd), 64'(n));
        checkOutput({name, "_exp_left"}, 64'(exp_wr_addr.size() + exp_wr_data.size() + exp_rd_addr.size()), 64'd0);
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_busy"}, 64'(busy), 64'd0);
        checkOutput({name, "_done"}, 64'(done), 64'd0);
        checkOutput({name, "_err_cnt"}, 64'(err_cnt), 64'd0);
        checkOutput({name, "_err_addr"}, 64'(err_addr), 64'd0);
        checkOutput({name, "_pass_cnt"}, 64'(pass_cnt), 64'd0);
        checkOutput({name, "_app_en"}, 64'(mig_bus.app_en), 64'd0);
        checkOutput({name, "_wdf_wren"}, 64'(mig_bus.app_wdf_wren), 64'd0);
        checkOutput({name, "_app_addr"}, 64'(mig_bus.app_addr), 64'd0);
        checkOutput({name, "_app_cmd"}, 64'(mig_bus.app_cmd), 64'd0);
        checkOutput({name, "_wdf_data_lo"}, mig_bus.app_wdf_data[63:0], 64'd0);
        checkOutput({name, "_wdf_data_hi"}, mig_bus.app_wdf_data[127:64], 64'd0);
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired, required run to complete");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        bit hit;
        rst = 1'b1;
        start = 1'b0;
        loop_en = 1'b0;
        start_addr = '0;
        num_words = '0;
        seed = '0;
        init_calib_complete = 1'b1;

        applyReset();
        @(negedge clk);
        checkResetValues("reset");
        checkOutput("wdf_end", 64'(mig_bus.app_wdf_end), 64'd1);
        checkOutput("wdf_mask", 64'(mig_bus.app_wdf_mask), 64'd0);
        checkOutput("side_reqs", 64'({mig_bus.app_sr_req, mig_bus.app_ref_req, mig_bus.app_zq_req}), 64'd0);

        $display("[TB] basic run");
        applyStimulus(28'h100, 4, 32'hCAFEBABE, 1'b0, 1);
        waitDone("basic");
        checkOutput("basic_pass", 64'(pass), 64'd1);
        checkOutput("basic_err_cnt", 64'(err_cnt), 64'd0);
        checkOutput("basic_pass_cnt", 64'(pass_cnt), 64'd1);
        checkOutput("basic_lane0", 64'(mem.exists(28'h100) ? mem[28'h100][31:0] : 32'h0), 64'hCAFEBABE);
        checkTraffic("basic", 4);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("basic_idle_done", 64'(done), 64'd0);

        $display("[TB] corrupted read beat 2");
        applyReset();
        corrupt_idx = 2;
        applyStimulus(28'h100, 4, 32'hCAFEBABE, 1'b0, 1);
        waitDone("corrupt");
        checkOutput("corrupt_err_cnt", 64'(err_cnt), 64'd1);
        checkOutput("corrupt_err_addr", 64'(err_addr), 64'h110);
        checkOutput("corrupt_pass", 64'(pass), 64'd0);
        corrupt_idx = -1;

        $display("[TB] random ready stalls");
        applyReset();
        rand_rdy = 1'b1;
        applyStimulus(28'h100, 4, 32'h12345678, 1'b0, 1);
        waitDone("stall");
        checkOutput("stall_pass", 64'(pass), 64'd1);
        checkTraffic("stall", 4);
        rand_rdy = 1'b0;

        $display("[TB] address wrap");
        applyReset();
        applyStimulus(28'hFFFFFF0, 4, 32'h0BADF00D, 1'b0, 1);
        waitDone("wrap");
        checkOutput("wrap_pass", 64'(pass), 64'd1);
        checkOutput("wrap_mem0", 64'(mem.exists(28'h0000000)), 64'd1);
        checkOutput("wrap_mem8_lane0", 64'(mem.exists(28'h0000008) ? mem[28'h0000008][31:0] : 32'h0), 64'h0BADF010);
        checkTraffic("wrap", 4);

        $display("[TB] loop of three passes");
        applyReset();
        applyStimulus(28'h200, 4, 32'h00001000, 1'b1, 3);
        hit = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (pass_cnt == 32'd2 && busy) begin
                hit = 1'b1;
                break;
            end
        end
        checkOutput("loop_second_pass_seen", 64'(hit), 64'd1);
        start = 1'b0;
        waitDone("loop");
        checkOutput("loop_pass_cnt", 64'(pass_cnt), 64'd3);
        checkOutput("loop_pass", 64'(pass), 64'd1);
        checkTraffic("loop", 12);
        repeat (2) @(negedge clk);
        checkOutput("loop_idle_done", 64'(done), 64'd0);
        checkOutput("loop_idle_busy", 64'(busy), 64'd0);

        $display("[TB] reset during read then empty run");
        applyReset();
        applyStimulus(28'h100, 4, 32'hCAFEBABE, 1'b0, 1);
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy && mig_bus.app_cmd == 3'b001) begin
                hit = 1'b1;
                break;
            end
        end
        checkOutput("midrst_read_seen", 64'(hit), 64'd1);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkResetValues("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_wr_addr.delete();
        exp_wr_data.delete();
        exp_rd_addr.delete();
        n_wr_cmd = 0;
        n_wr_data = 0;
        n_rd_cmd = 0;
        applyStimulus(28'h100, 0, 32'h1, 1'b0, 1);
        waitDone("empty");
        checkOutput("empty_pass", 64'(pass), 64'd1);
        checkOutput("empty_busy", 64'(busy), 64'd0);
        checkTraffic("empty", 0);
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
